// File: rtl/load_writeback_pkg.sv
// Shared definitions for the load write-back stage: load-type encodings,
// FSM states and register-file address width.
package load_writeback_pkg;

  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    WRITE    = 2'd2
  } state_t;

endpackage

// File: rtl/load_extract.sv
// Byte/halfword/word lane extraction with sign or zero extension, plus an
// alignment/legality check for the given load type and address offset.
module load_extract
  import load_writeback_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result,
  output logic        align_ok
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? data[31:16] : data[15:0];

  always_comb begin
    result   = '0;
    align_ok = 1'b0;
    case (funct3)
      F3_LB: begin
        result   = {{24{byte_sel[7]}}, byte_sel};
        align_ok = 1'b1;
      end
      F3_LBU: begin
        result   = {24'b0, byte_sel};
        align_ok = 1'b1;
      end
      F3_LH: begin
        result   = {{16{half_sel[15]}}, half_sel};
        align_ok = ~addr_lo[0];
      end
      F3_LHU: begin
        result   = {16'b0, half_sel};
        align_ok = ~addr_lo[0];
      end
      F3_LW: begin
        result   = data;
        align_ok = (addr_lo == 2'b00);
      end
      default: begin
        result   = '0;
        align_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load write-back stage: accepts a tagged load, waits for the memory
// response with a timeout, extends the data and pulses a register write.
module load_writeback
  import load_writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [2:0]        req_funct3,
  input  logic [1:0]        req_addr_lo,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              reg_write,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [31:0]       reg_wdata,
  output logic              busy,
  output logic              err_align,
  output logic              err_timeout
);

  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [REG_AW-1:0] rd_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        addr_lo_reg;
  logic [TMR_W-1:0]  timer_reg;

  logic        accept;
  logic        timer_done;
  logic [2:0]  ext_funct3;
  logic [1:0]  ext_addr_lo;
  logic [31:0] ext_result;
  logic        ext_align_ok;

  assign req_ready  = (state_reg == IDLE);
  assign accept     = req_valid && req_ready;
  assign timer_done = (timer_reg == TMR_LIMIT);

  // One extractor serves both uses: in IDLE it checks the incoming request,
  // while waiting it extracts from the response using the latched fields.
  assign ext_funct3  = (state_reg == IDLE) ? req_funct3  : funct3_reg;
  assign ext_addr_lo = (state_reg == IDLE) ? req_addr_lo : addr_lo_reg;

  load_extract u_extract (
    .data     (mem_rsp_data),
    .funct3   (ext_funct3),
    .addr_lo  (ext_addr_lo),
    .result   (ext_result),
    .align_ok (ext_align_ok)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept && ext_align_ok) state_next = WAIT_RSP;
      WAIT_RSP: begin
        // A response in the same cycle as the timer limit takes priority.
        if (mem_rsp_valid)   state_next = WRITE;
        else if (timer_done) state_next = IDLE;
      end
      WRITE:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_reg      <= '0;
      funct3_reg  <= '0;
      addr_lo_reg <= '0;
      timer_reg   <= '0;
      reg_write   <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      busy        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_reg   <= state_next;
      busy        <= (state_next != IDLE);
      reg_write   <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rd_reg      <= req_rd;
            funct3_reg  <= req_funct3;
            addr_lo_reg <= req_addr_lo;
            timer_reg   <= '0;
            err_align   <= ~ext_align_ok;
          end
        end
        WAIT_RSP: begin
          timer_reg <= timer_reg + 1'b1;
          if (mem_rsp_valid) begin
            reg_write <= (rd_reg != '0);
            reg_waddr <= rd_reg;
            reg_wdata <= ext_result;
          end else if (timer_done) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_writeback.md
Name: load_writeback

Overview:
- Write-back stage directly downstream of the load datapath.
- Accepts a load request tagged with destination register, load type and low address bits.
- Waits for the data-memory response, then extracts and extends the byte, halfword or word.
- Issues a single-cycle register-file write.
- Flags misaligned or illegal requests and memory timeouts without writing.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT_RSP before abort; legal range 2..255.
- TMR_W, 8: timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_rd  in  5  destination register.
- req_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- req_addr_lo  in  2  effective address bits [1:0].
- mem_rsp_valid  in  1  memory read data valid.
- mem_rsp_data  in  32  aligned memory word.
- reg_write  out  1  register-file write enable, one-cycle pulse.
- reg_waddr  out  5  write address.
- reg_wdata  out  32  extended load result.
- busy  out  1  high in WAIT_RSP or WRITE.
- err_align  out  1  one-cycle pulse: misaligned or illegal request.
- err_timeout  out  1  one-cycle pulse: no response within TIMEOUT_CYCLES.

Behaviour:
- Reset state: IDLE. reg_write, reg_waddr, reg_wdata, err_align, err_timeout, busy all 0. Latched request fields and timer cleared.
- All outputs are registered except req_ready, which is (state == IDLE).
- A request is accepted when req_valid && req_ready. On acceptance, rd, funct3 and addr_lo are latched.
- Request checks at acceptance:
  - Illegal funct3 (011, 110, 111) -> err_align pulses the next cycle; state stays IDLE; no write.
  - Misaligned: lh/lhu with addr_lo[0]=1, or lw with addr_lo!=0 -> same handling as illegal funct3.
  - Otherwise -> WAIT_RSP with timer=0.
- WAIT_RSP:
  - Timer increments each cycle.
  - mem_rsp_valid -> latch the extracted result and go to WRITE.
  - Timer == TIMEOUT_CYCLES-1 with no response -> err_timeout pulses the next cycle; go to IDLE; no write.
  - If a response arrives in the same cycle the timer hits its limit, the response wins.
- WRITE:
  - reg_write=1 for exactly one cycle, with reg_waddr=rd and reg_wdata=result; then go to IDLE.
  - If rd==0, reg_write stays 0 but the state still passes through WRITE.
  - reg_waddr and reg_wdata hold their last values outside WRITE.
- mem_rsp_valid in IDLE or WRITE, or in the acceptance cycle itself, is ignored.
- Latency: request accepted at cycle N, response at cycle M (M ≥ N+1) -> reg_write high at M+1.
- Throughput: at most one load per 3 cycles.
- Extraction rules:
  - lb/lbu: byte = data[8*addr_lo +: 8].
  - lh/lhu: half = data[16*addr_lo[1] +: 16].
  - lw: the full word.
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend.
- Reset asserted in any state, including mid-WAIT_RSP: return to IDLE, no write, no error pulse; a pending response is dropped.

Decomposition:
- Shared package:
  - funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - State enum: IDLE, WAIT_RSP, WRITE.
  - Register address width constant (5).
- Sub-module load_extract: combinational; inputs data, funct3, addr_lo; outputs a 32-bit result and an align_ok flag. It is reused by the future store-path byte-lane logic.

Test Plan:
- lw, rd=5, addr_lo=0; response 0xDEADBEEF two cycles after accept -> reg_write=1, waddr=5, wdata=0xDEADBEEF one cycle after the response; busy low the following cycle.
- lb, rd=3, addr_lo=2, data 0x1280FF00 -> wdata=0xFFFFFF80. Repeat as lbu -> 0x00000080.
- lhu, addr_lo=2, data 0xBEEF1234 -> wdata=0x0000BEEF. Repeat as lh with addr_lo=1 -> err_align pulse, no reg_write, req_ready stays high.
- Valid lw with no response -> err_timeout pulses exactly TIMEOUT_CYCLES+1 cycles after accept (17 with default); no reg_write. A response arriving later is ignored.
- lw to rd=0 with valid response -> reg_write stays 0; busy sequence is identical to the rd≠0 case.
- reset asserted for 1 cycle mid-WAIT_RSP, response arrives the next cycle -> no reg_write, no error, req_ready=1.
